// File: rtl/gene_sweep.sv
// Sweep controller for the 8-gene Boolean network: walks every initial state,
// steps the network through x_next, and reports hit/miss from the cycle detector.
module gene_sweep #(
  parameter int MAX_STEPS = 16,
  parameter int SETTLE    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x_next,
  input  logic       flag_in,
  output logic [7:0] init_val_chk,
  output logic [7:0] x,
  output logic       busy,
  output logic       res_valid,
  output logic [7:0] res_init,
  output logic       res_hit,
  output logic [8:0] cyc_count,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    REPORT,
    DONE
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);
  localparam logic [7:0] SETTLE_K  = 8'(SETTLE);

  state_t     state;
  logic [7:0] init;
  logic [7:0] step_cnt;
  logic       hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      init         <= 8'd0;
      step_cnt     <= 8'd0;
      hit          <= 1'b0;
      x            <= 8'd0;
      init_val_chk <= 8'hFF;  // first LOAD of 0 must look like a change
      cyc_count    <= 9'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            init      <= 8'd0;
            cyc_count <= 9'd0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          init_val_chk <= init;
          x            <= init;
          step_cnt     <= 8'd0;
          state        <= STEP;
        end
        STEP: begin
          x        <= x_next;
          step_cnt <= step_cnt + 8'd1;
          // A flag on the final step still counts as a hit.
          if (flag_in && (step_cnt >= SETTLE_K)) begin
            hit   <= 1'b1;
            state <= REPORT;
          end else if (step_cnt == LAST_STEP) begin
            hit   <= 1'b0;
            state <= REPORT;
          end
        end
        REPORT: begin
          cyc_count <= cyc_count + {8'd0, hit};
          if (init == 8'hFF) begin
            state <= DONE;
          end else begin
            init  <= init + 8'd1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == LOAD) || (state == STEP) || (state == REPORT);
  assign res_valid = (state == REPORT);
  assign res_init  = init;
  assign res_hit   = hit;
  assign done      = (state == DONE);

endmodule

// File: tb/tb_gene_sweep.sv
// Self-checking bench for gene_sweep: a behavioural per-initial-state model
// predicts the report stream, trajectory and timing checked every cycle.
module tb_gene_sweep;

  localparam int MAX_STEPS_TB = 16;
  localparam int SETTLE_TB    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x_next;
  logic       flag_in;
  logic [7:0] init_val_chk;
  logic [7:0] x;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_init;
  logic       res_hit;
  logic [8:0] cyc_count;
  logic       done;

  gene_sweep #(.MAX_STEPS(MAX_STEPS_TB), .SETTLE(SETTLE_TB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x_next      (x_next),
    .flag_in     (flag_in),
    .init_val_chk(init_val_chk),
    .x           (x),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_init    (res_init),
    .res_hit     (res_hit),
    .cyc_count   (cyc_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int per;

  // Network and detector stand-ins: 0 identity, 1 increment, 2 random table;
  // flag 0 low, 1 high, 2 period<=2 detect, 3 random, 4 only init 7 at x 22.
  int         net_mode  = 0;
  int         flag_mode = 0;
  logic [7:0] lut [256];
  logic       gtab[256];

  function automatic logic [7:0] f_net(input logic [7:0] v);
    case (net_mode)
      0:       return v;
      1:       return v + 8'd1;
      default: return lut[v];
    endcase
  endfunction

  function automatic logic g_flag(input logic [7:0] iv, input logic [7:0] v);
    case (flag_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (f_net(v) == v) || (f_net(f_net(v)) == v);
      3:       return gtab[v ^ iv];
      default: return (iv == 8'd7) && (v == 8'd22);
    endcase
  endfunction

  assign x_next  = f_net(x);
  assign flag_in = g_flag(init_val_chk, x);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (period %0d): got %0d expected %0d", name, per, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    per++;
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_ivc", init_val_chk, 8'hFF);
    check("rst_x", x, 0);
    check("rst_cyc", cyc_count, 0);
    check("rst_res_init", res_init, 0);
    check("rst_res_hit", res_hit, 0);
  endtask

  // Model: the network state at step k is f^k(init); the first k >= SETTLE
  // whose state raises the flag is the hit step, else miss after MAX_STEPS.
  task automatic model(input logic [7:0] iv, output int kend, output logic eh);
    logic [7:0] xv;
    xv   = iv;
    kend = MAX_STEPS_TB - 1;
    eh   = 1'b0;
    for (int k = 0; k < MAX_STEPS_TB; k++) begin
      if (k >= SETTLE_TB && g_flag(iv, xv)) begin
        kend = k;
        eh   = 1'b1;
        break;
      end
      xv = f_net(xv);
    end
  endtask

  // Full sweep walked in lockstep with the model. fin_lit/gap_lit < 0 skip the
  // literal pins; abort_init >= 0 resets mid-STEP for that initial state.
  task automatic run_sweep(input int fin_lit, input int gap_lit, input bit poke,
                           input int abort_init);
    int         hits;
    int         last_rep;
    int         kend;
    logic       eh;
    logic [7:0] xv;
    hits     = 0;
    last_rep = -1;
    start    = 1'b1;
    per      = 0;
    tick();                               // now in LOAD of init 0 (period 1)
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model(8'(i), kend, eh);
      check("load_busy", busy, 1);
      check("load_res_valid", res_valid, 0);
      check("load_done", done, 0);
      check("load_cyc", cyc_count, hits);
      xv = 8'(i);
      for (int k = 0; k <= kend; k++) begin
        start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        check("step_x", x, xv);
        check("step_ivc", init_val_chk, i);
        check("step_busy", busy, 1);
        check("step_res_valid", res_valid, 0);
        check("step_cyc", cyc_count, hits);
        xv = f_net(xv);
        if (i == abort_init && k == 5) begin
          start = 1'b0;
          rst   = 1'b1;
          tick();
          rst = 1'b0;
          check_reset_vals();
          return;
        end
      end
      tick();                             // REPORT
      start = 1'b0;
      check("rep_valid", res_valid, 1);
      check("rep_busy", busy, 1);
      check("rep_init", res_init, i);
      check("rep_hit", res_hit, eh);
      check("rep_ivc", init_val_chk, i);
      check("rep_cyc", cyc_count, hits);
      if (gap_lit > 0 && last_rep >= 0) check("rep_gap", per - last_rep, gap_lit);
      last_rep = per;
      hits += int'(eh);
      tick();                             // next LOAD or DONE
    end
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_cyc", cyc_count, hits);
    if (fin_lit >= 0) check("done_cyc_lit", cyc_count, fin_lit);
    if (gap_lit == 18) check("done_cycle_lit", per, 4609);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("hold_done", done, 1);
      check("hold_res_valid", res_valid, 0);
      check("hold_cyc", cyc_count, hits);
      check("hold_x_busy", busy, 0);
    end
  endtask

  initial begin
    per   = 0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      lut[i]  = 8'($urandom_range(0, 255));
      gtab[i] = ($urandom_range(0, 3) == 0);
    end
    tick();
    tick();
    rst = 1'b0;
    check_reset_vals();
    tick();
    check("idle_done", done, 0);

    net_mode = 0; flag_mode = 2;          // identity network: all hits at k=3
    run_sweep(256, 6, 1'b0, -1);
    net_mode = 1; flag_mode = 0;          // all miss, restart from DONE
    run_sweep(0, 18, 1'b1, -1);
    net_mode = 1; flag_mode = 1;          // early flags ignored, hit at k=3
    run_sweep(256, 6, 1'b1, -1);
    net_mode = 1; flag_mode = 4;          // flag only on last step of init 7
    run_sweep(1, -1, 1'b0, -1);
    net_mode = 1; flag_mode = 0;          // reset while init=100 in STEP
    run_sweep(-1, 18, 1'b0, 100);
    tick();
    check_reset_vals();
    net_mode = 2; flag_mode = 3;
    run_sweep(-1, -1, 1'b1, -1);
    net_mode = 2; flag_mode = 2;
    run_sweep(-1, -1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gene_sweep.md
# gene_sweep

Stimulus generator and sweep controller for the 8-gene Boolean network. It walks every 8-bit initial state, loads it, and steps the network through an external next-state function. It drives the cycle detector's `init_val_chk`/`x` inputs and reads back its cycle flag. For each initial state it reports hit (period-≤2 attractor reached) or miss (step budget exhausted) and keeps a running hit count.

## Interface

- `MAX_STEPS`, 16: STEP cycles allowed per initial state before declaring a miss (≥ SETTLE+1, ≤ 255).
- `SETTLE`, 3: STEP cycles during which `flag_in` is ignored; this covers detector warm-up.

- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `x_next` input 8: network next state f(`x`), combinational from `x`.
- `flag_in` input 1: cycle flag from the detector.
- `init_val_chk` output 8: initial state currently under test; a change re-arms the detector.
- `x` output 8: current network state, fed to both the network function and the detector.
- `busy` output 1: high in LOAD, STEP and REPORT.
- `res_valid` output 1: one-cycle pulse per initial state, in REPORT.
- `res_init` output 8: initial state being reported; valid with `res_valid`.
- `res_hit` output 1: 1 = cycle detected, 0 = miss; valid with `res_valid`.
- `cyc_count` output 9: number of hits in the current or last sweep (0..256).
- `done` output 1: high in DONE.

## Operation

- FSM states: IDLE, LOAD, STEP, REPORT, DONE.
- Internal registers: `init` (8b), `step_cnt` (8b), `hit` (1b).
- IDLE:
  - `start`=1: `init`←0, `cyc_count`←0, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD (1 cycle):
  - `init_val_chk`←`init`, `x`←`init`, `step_cnt`←0.
  - Go to STEP.
- STEP (every cycle):
  - `x`←`x_next`, `step_cnt`←`step_cnt`+1.
  - Evaluate with the current `step_cnt`=k:
    - If `flag_in`=1 and k≥SETTLE: `hit`←1, go to REPORT.
    - Else if k=MAX_STEPS−1: `hit`←0, go to REPORT.
    - Otherwise stay in STEP.
  - Flag takes priority on the final step.
- REPORT (1 cycle):
  - `res_valid`=1, `res_init`=`init`, `res_hit`=`hit`.
  - `cyc_count`←`cyc_count`+`hit`.
  - If `init`=255, go to DONE; else `init`←`init`+1, go to LOAD.
- DONE:
  - `done`=1.
  - Outputs hold their values.
  - `start`=1 restarts exactly as from IDLE, including clearing `cyc_count`.
- `start` in LOAD, STEP or REPORT is ignored.
- `init` wraps only logically: reaching 255 terminates the sweep, with no increment to 0.
- `cyc_count` is 9 bits so that 256 hits does not overflow.

## Timing

- Reset values:
  - FSM = IDLE.
  - `init_val_chk`=8'hFF, so that the first LOAD of 0 is a change.
  - `x`=0, `busy`=0, `res_valid`=0, `res_init`=0, `res_hit`=0, `cyc_count`=0, `done`=0.
- Reset mid-sweep: the next cycle is IDLE with the reset values above. No partial `res_valid` is issued.
- Every LOAD changes `init_val_chk` (0xFF→0x00, then +1 each time), so the detector is re-armed once per initial state.
- `res_valid`, `res_hit`, `res_init` and `done` are combinational from FSM state and registers.
- Cycles per initial state:
  - Hit at step k: 1 + (k+1) + 1.
  - Miss: MAX_STEPS+2.
- `done` rises the cycle after the REPORT for `init`=255.
- Full-miss sweep with defaults: `start` sampled at cycle 0, `done` first high at cycle 1+256·18 = 4609.

## Test plan

- Identity network (`x_next`=`x`) with a real detector → all 256 reports have `res_hit`=1, and each within MAX_STEPS; final `cyc_count`=256.
- `x_next`=`x`+1, `flag_in` tied 0 → 256 reports with `res_hit`=0, each 18 cycles apart; `cyc_count`=0; `done` at cycle 4609.
- `flag_in` tied 1 → every report is a hit at step k=3; reports are 6 cycles apart. Early flags at k<3 are ignored.
- `flag_in` raised only at k=15 for `init`=7 → `res_hit`=1 for `init`=7 (flag beats timeout); all others miss; `cyc_count`=1.
- `rst` asserted while `init`=100 in STEP → the next cycle is IDLE, `init_val_chk`=FF, `cyc_count`=0. A new `start` begins at `init`=0.
- Pulse `start` during STEP → no effect on sequence. `start` in DONE → new sweep, and `cyc_count` is cleared at the first LOAD.
